// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider.
// Holds the FSM state encoding, datapath widths and the latched request payload.
package div_unit_pkg;

  localparam int unsigned DIV_DVD_W       = 32;
  localparam int unsigned DIV_DVS_W       = 16;
  localparam int unsigned DIV_REM_W       = 17;
  localparam int unsigned DIV_CNT_W       = 4;
  localparam int unsigned DIV_ERR_LATENCY = 2;

  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_CHECK,
    DIV_ITER,
    DIV_FIXUP,
    DIV_DONE
  } div_state_e;

  typedef struct packed {
    logic                 wide;
    logic                 is_signed;
    logic [DIV_DVD_W-1:0] dividend;
    logic [DIV_DVS_W-1:0] divisor;
  } div_req_t;

  // Conditional two's-complement negate of a 16-bit magnitude.
  function automatic logic [DIV_DVS_W-1:0] div_cneg16(input logic [DIV_DVS_W-1:0] v,
                                                      input logic en);
    return en ? DIV_DVS_W'(-v) : v;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift/subtract step: shifts a dividend bit into the partial
// remainder and subtracts the divisor when it fits.
module div_step
  import div_unit_pkg::*;
(
  input  logic [DIV_REM_W-1:0] i_rem,
  input  logic                 i_bit,
  input  logic [DIV_DVS_W-1:0] i_divisor,
  output logic [DIV_REM_W-1:0] o_rem_c,
  output logic                 o_qbit_c
);

  localparam int unsigned SW = DIV_REM_W + 1;

  logic [SW-1:0] w_shift;
  logic [SW-1:0] w_diff;

  always_comb begin
    w_shift  = {i_rem, i_bit};
    w_diff   = w_shift - SW'(i_divisor);
    o_qbit_c = (w_shift >= SW'(i_divisor));
    o_rem_c  = o_qbit_c ? DIV_REM_W'(w_diff) : DIV_REM_W'(w_shift);
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIVU/DIV, 16/8 and 32/16) for the execution unit.
// Resolves BITS_PER_CYCLE quotient bits per ITER cycle; errors hold the old results.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 wide,
  input  logic                 is_signed,
  input  logic [DIV_DVD_W-1:0] dividend,
  input  logic [DIV_DVS_W-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_error,
  output logic [DIV_DVS_W-1:0] quotient,
  output logic [DIV_DVS_W-1:0] remainder
);

  localparam int unsigned BPC       = BITS_PER_CYCLE;
  localparam int unsigned ITER_WIDE = DIV_DVS_W / BPC;
  localparam int unsigned ITER_BYTE = (DIV_DVS_W / 2) / BPC;
  localparam logic [DIV_CNT_W-1:0] CNT_WIDE = DIV_CNT_W'(ITER_WIDE - 1);
  localparam logic [DIV_CNT_W-1:0] CNT_BYTE = DIV_CNT_W'(ITER_BYTE - 1);

  div_state_e r_state;
  div_state_e w_state_nxt;

  div_req_t               r_req;
  logic                   r_sign_q;
  logic                   r_sign_r;
  logic [DIV_REM_W-1:0]   r_prem;
  logic [DIV_DVS_W-1:0]   r_lo;
  logic [DIV_DVS_W-1:0]   r_qmag;
  logic [DIV_DVS_W-1:0]   r_dvs;
  logic [DIV_CNT_W-1:0]   r_cnt;

  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;
  logic [DIV_DVS_W-1:0]   r_quot;
  logic [DIV_DVS_W-1:0]   r_rmd;

  logic                   w_busy_nxt;
  logic                   w_done_nxt;
  logic                   w_err_nxt;
  logic                   w_load_res;

  logic                   w_dvd_sign;
  logic                   w_dvs_sign;
  logic [DIV_DVD_W-1:0]   w_dvd_mag;
  logic [DIV_DVS_W-1:0]   w_dvs_mag;
  logic [DIV_DVS_W-1:0]   w_hi;
  logic [DIV_DVS_W-1:0]   w_lo;
  logic                   w_chk_err;

  logic [DIV_DVS_W-1:0]   w_q_lim;
  logic                   w_range_err;
  logic [DIV_DVS_W-1:0]   w_q_fix;
  logic [DIV_DVS_W-1:0]   w_r_fix;
  logic [DIV_DVS_W-1:0]   w_quot_res;
  logic [DIV_DVS_W-1:0]   w_rmd_res;

  logic [DIV_REM_W-1:0]   w_prem [BPC+1];
  logic [BPC-1:0]         w_qbits;

  assign busy      = r_busy;
  assign done      = r_done;
  assign div_error = r_err;
  assign quotient  = r_quot;
  assign remainder = r_rmd;

  // Operand magnitudes, split into the high half (must be < divisor) and the bits to shift in.
  always_comb begin
    w_dvd_sign = r_req.is_signed & (r_req.wide ? r_req.dividend[31] : r_req.dividend[15]);
    w_dvs_sign = r_req.is_signed & (r_req.wide ? r_req.divisor[15]  : r_req.divisor[7]);

    if (r_req.wide) begin
      w_dvd_mag = w_dvd_sign ? DIV_DVD_W'(-r_req.dividend) : r_req.dividend;
      w_dvs_mag = div_cneg16(r_req.divisor, w_dvs_sign);
      w_hi      = w_dvd_mag[31:16];
      w_lo      = w_dvd_mag[15:0];
    end else begin
      w_dvd_mag = {16'h0000, div_cneg16(r_req.dividend[15:0], w_dvd_sign)};
      w_dvs_mag = {8'h00, (w_dvs_sign ? 8'(-r_req.divisor[7:0]) : r_req.divisor[7:0])};
      w_hi      = {8'h00, w_dvd_mag[15:8]};
      w_lo      = {w_dvd_mag[7:0], 8'h00};
    end

    w_chk_err = (w_dvs_mag == '0) || (w_hi >= w_dvs_mag);
  end

  assign w_prem[0] = r_prem;

  for (genvar g = 0; g < BPC; g++) begin : gen_step
    div_step u_step (
      .i_rem     (w_prem[g]),
      .i_bit     (r_lo[DIV_DVS_W-1-g]),
      .i_divisor (r_dvs),
      .o_rem_c   (w_prem[g+1]),
      .o_qbit_c  (w_qbits[BPC-1-g])
    );
  end

  // Sign restore and signed range check; negative quotients may reach one past the positive limit.
  always_comb begin
    if (r_sign_q) begin
      w_q_lim = r_req.wide ? 16'h8000 : 16'h0080;
    end else begin
      w_q_lim = r_req.wide ? 16'h7FFF : 16'h007F;
    end
    w_range_err = r_req.is_signed && (r_qmag > w_q_lim);
    w_q_fix     = div_cneg16(r_qmag, r_sign_q);
    w_r_fix     = div_cneg16(r_prem[DIV_DVS_W-1:0], r_sign_r);
    w_quot_res  = r_req.wide ? w_q_fix : {8'h00, w_q_fix[7:0]};
    w_rmd_res   = r_req.wide ? w_r_fix : {8'h00, w_r_fix[7:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_load_res  = 1'b0;

    case (r_state)
      DIV_IDLE: begin
        if (start) begin
          w_state_nxt = DIV_CHECK;
        end
      end
      DIV_CHECK: begin
        if (w_chk_err) begin
          w_state_nxt = DIV_DONE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt = DIV_ITER;
        end
      end
      DIV_ITER: begin
        if (r_cnt == '0) begin
          w_state_nxt = DIV_FIXUP;
        end
      end
      DIV_FIXUP: begin
        w_state_nxt = DIV_DONE;
        w_done_nxt  = 1'b1;
        w_err_nxt   = w_range_err;
        w_load_res  = !w_range_err;
      end
      DIV_DONE: begin
        w_state_nxt = DIV_IDLE;
      end
      default: begin
        w_state_nxt = DIV_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == DIV_CHECK) || (w_state_nxt == DIV_ITER) ||
                 (w_state_nxt == DIV_FIXUP);
  end

  // Registered status and results; results only move on an error-free completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_quot <= '0;
      r_rmd  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      if (w_load_res) begin
        r_quot <= w_quot_res;
        r_rmd  <= w_rmd_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_prem   <= '0;
      r_lo     <= '0;
      r_qmag   <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            r_req.wide      <= wide;
            r_req.is_signed <= is_signed;
            r_req.dividend  <= dividend;
            r_req.divisor   <= divisor;
          end
        end
        DIV_CHECK: begin
          r_sign_q <= w_dvd_sign ^ w_dvs_sign;
          r_sign_r <= w_dvd_sign;
          r_prem   <= {1'b0, w_hi};
          r_lo     <= w_lo;
          r_dvs    <= w_dvs_mag;
          r_qmag   <= '0;
          r_cnt    <= r_req.wide ? CNT_WIDE : CNT_BYTE;
        end
        DIV_ITER: begin
          r_prem <= w_prem[BPC];
          r_lo   <= r_lo << BPC;
          r_qmag <= DIV_DVS_W'({r_qmag, w_qbits});
          r_cnt  <= DIV_CNT_W'(r_cnt - 1'b1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative divider for the NEC core execution unit.
- Performs the inverse of the multiply path: DIVU/DIV in byte form (16/8) and word form (32/16).
- Receives operands from the microcode sequencer and returns the quotient, the remainder, and a divide-error indication.
- The sequencer stalls on busy and raises the divide-error exception when div_error is set.

Parameters:
- BITS_PER_CYCLE, 1, quotient bits resolved per iteration cycle; legal values are 1 or 2.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a division; sampled only in IDLE
- wide  input  1  1 = word (32/16), 0 = byte (16/8)
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU
- dividend  input  32  byte mode uses [15:0] only
- divisor  input  16  byte mode uses [7:0] only
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle completion pulse
- div_error  output  1  valid while done=1: divide by zero or quotient overflow
- quotient  output  16  byte mode drives [15:8]=0
- remainder  output  16  byte mode drives [15:8]=0

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, div_error=0, quotient=0, remainder=0.
- Operands are latched when start=1 in IDLE (cycle 0); inputs are don't-care afterwards.
- States:
  - IDLE -> CHECK on start.
  - CHECK: take magnitudes of dividend and divisor when is_signed; record sign_q = sign(dividend) ^ sign(divisor) and sign_r = sign(dividend).
  - CHECK -> DONE (error) if |divisor|==0 or the magnitude high half (hi16, or hi8 in byte mode) >= |divisor|.
  - CHECK -> ITER otherwise.
- ITER: restoring shift/subtract for I = N/BITS_PER_CYCLE cycles, where N = 16 (wide) or 8 (byte). An iteration counter decrements to 0, then the state moves to FIXUP.
- FIXUP:
  - Negate the quotient magnitude if sign_q; negate the remainder magnitude if sign_r.
  - Signed range check on the quotient magnitude: positive results must be <= 0x7FFF (byte 0x7F); negative results must be <= 0x8000 (byte 0x80). A violation is an error.
  - FIXUP -> DONE.
- DONE:
  - done=1 for exactly one cycle, div_error per the checks above.
  - quotient/remainder are updated only when div_error=0; on error they hold their previous values.
  - DONE -> IDLE.
- Latency: error detected in CHECK gives done in cycle 2. Otherwise done arrives in cycle I+3: 19 for wide and 11 for byte when BITS_PER_CYCLE=1.
- busy: high in CHECK, ITER and FIXUP; low in DONE and IDLE.
- Division truncates toward zero. The remainder carries the dividend's sign. Unsigned mode performs no FIXUP negation or range check.
- start while not IDLE is ignored (no queuing). start in the same cycle as reset is ignored.
- Reset mid-operation returns to IDLE immediately, no done pulse is produced, and quotient/remainder are cleared.
- quotient/remainder are stable between operations, and from DONE until the next successful DONE.

Decomposition:
- types package gains:
  - div_state_e (DIV_IDLE, DIV_CHECK, DIV_ITER, DIV_FIXUP, DIV_DONE)
  - constant DIV_ERR_LATENCY=2
- Sub-module div_step: combinational single-bit restoring step.
  - Inputs: partial remainder (17b), next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated BITS_PER_CYCLE times in a chain.

Test Plan:
- Unsigned wide, dividend=0x00010000, divisor=0x0003 -> quotient=0x5555, remainder=0x0001, div_error=0, done in cycle 19, busy in cycles 1–18.
- Signed byte, dividend=0xFF9C (-100), divisor=0x0007 -> quotient=0x00F2 (-14), remainder=0x00FE (-2), done in cycle 11.
- Divide by zero (any mode, divisor=0), with prior quotient=0x5555 -> done+div_error in cycle 2, quotient stays 0x5555.
- Unsigned overflow, dividend=0x00020000, divisor=0x0001 -> div_error in cycle 2.
- Signed boundary:
  - dividend=0xFFFF8000 / divisor=0x0001 -> quotient=0x8000, no error.
  - dividend=0x00008000 / divisor=0x0001 -> div_error in cycle 19 (FIXUP range check).
- Control:
  - start pulsed during ITER is ignored, giving exactly one done.
  - reset asserted in cycle 5 of a wide op gives no done, busy=0 next cycle, quotient=remainder=0.
  - A fresh start then completes normally.
  - Repeat all cases with BITS_PER_CYCLE=2, expecting wide done in cycle 11 and byte done in cycle 7.
